// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin sync, ps2_clk glitch filter, frame check with
// mid-frame timeout, and a first-word-fall-through byte FIFO with selectable overflow policy.
module ps2_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 2000,
  parameter int unsigned OVF_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [7:0]            data,
  output logic                  valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned FW    = 4;
  localparam int unsigned TW    = 16;
  localparam int unsigned BW    = 4;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] fcnt;
  logic          strobe;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] timer;
  logic [9:0]    sr;
  logic          push_req;
  logic [7:0]    push_byte;
  logic          frame_ok_c, ferr_set_c, tmo_c;

  logic [AW-1:0] w_ptr, r_ptr, r_nxt_c;
  logic [LW-1:0] lvl_nxt_c;
  logic          full_c, do_pop_c, do_push_c, ovw_c, ovf_set_c;
  logic [7:0]    mem [DEPTH];

  // Two-flop synchronisers plus a hold-time filter; strobe marks a filtered falling edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_clk <= 1'b1;
      fcnt     <= '0;
      strobe   <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      strobe <= 1'b0;
      if (clk_s2 != filt_clk) begin
        if (fcnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s2;
          fcnt     <= '0;
          strobe   <= ~clk_s2;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  // After ten shifts sr holds start at [0], data at [8:1], parity at [9].
  always_comb begin
    frame_ok_c = ~sr[0] & dat_s2 & (^sr[9:1]);
    tmo_c      = ~strobe & (bcnt != '0) & (timer == TW'(TIMEOUT - 1));
    ferr_set_c = tmo_c | (strobe & (bcnt == BW'(10)) & ~frame_ok_c);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bcnt      <= '0;
      timer     <= '0;
      sr        <= '0;
      push_req  <= 1'b0;
      push_byte <= '0;
      frame_err <= 1'b0;
    end else begin
      push_req  <= 1'b0;
      frame_err <= ferr_set_c | (frame_err & ~err_clr);
      if (strobe) begin
        timer <= '0;
        if (bcnt == BW'(10)) begin
          bcnt <= '0;
          if (frame_ok_c) begin
            push_req  <= 1'b1;
            push_byte <= sr[8:1];
          end
        end else begin
          sr   <= {dat_s2, sr[9:1]};
          bcnt <= bcnt + BW'(1);
        end
      end else if (bcnt != '0) begin
        if (tmo_c) begin
          bcnt  <= '0;
          timer <= '0;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

  // FIFO control: pop frees a slot before a same-cycle push is judged against full.
  always_comb begin
    full_c    = (level == LW'(DEPTH));
    do_pop_c  = rd_en & valid;
    ovw_c     = push_req & full_c & ~do_pop_c & (OVF_MODE != 0);
    ovf_set_c = push_req & full_c & ~do_pop_c;
    do_push_c = push_req & (~full_c | do_pop_c | (OVF_MODE != 0));
    r_nxt_c   = r_ptr + AW'(do_pop_c | ovw_c);
    lvl_nxt_c = level;
    if (do_push_c && !do_pop_c && !ovw_c) lvl_nxt_c = level + LW'(1);
    else if (do_pop_c && !do_push_c)      lvl_nxt_c = level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[w_ptr] <= push_byte;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      w_ptr    <= '0;
      r_ptr    <= '0;
      level    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      data     <= '0;
    end else begin
      if (do_push_c) w_ptr <= w_ptr + AW'(1);
      r_ptr    <= r_nxt_c;
      level    <= lvl_nxt_c;
      valid    <= (lvl_nxt_c != '0);
      overflow <= ovf_set_c | (overflow & ~err_clr);
      // Registered head: bypass the incoming byte when it lands in the head slot.
      if (do_push_c && (w_ptr == r_nxt_c)) data <= push_byte;
      else                                 data <= mem[r_nxt_c];
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: two instances (drop / overwrite policy) on shared pins,
// compared each settled cycle against queue models of the received bytes.
module tb_ps2_rx_fifo;

  localparam int HALF    = 60;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 2000;

  logic       clk = 1'b0;
  logic       clr, ps2_clk, ps2_data, rd_en, err_clr;
  logic [7:0] data0, data1;
  logic       valid0, valid1, ovf0, ovf1, ferr0, ferr1;
  logic [3:0] level0, level1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       m_ovf0, m_ovf1, m_ferr;
  logic       chk_en;
  int         n_chk, n_fail;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.DEPTH_LOG2(3), .FILTER_LEN(4), .TIMEOUT(TIMEOUT), .OVF_MODE(0)) dut0 (
    .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .err_clr(err_clr), .data(data0), .valid(valid0), .level(level0),
    .overflow(ovf0), .frame_err(ferr0));

  ps2_rx_fifo #(.DEPTH_LOG2(3), .FILTER_LEN(4), .TIMEOUT(TIMEOUT), .OVF_MODE(1)) dut1 (
    .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .err_clr(err_clr), .data(data1), .valid(valid1), .level(level1),
    .overflow(ovf1), .frame_err(ferr1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the models whenever the bench marks outputs settled.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_level0", 32'(level0), 32'(q0.size()));
      check("m_valid0", 32'(valid0), 32'(q0.size() != 0));
      if (q0.size() != 0) check("m_data0", 32'(data0), 32'(q0[0]));
      check("m_ovf0", 32'(ovf0), 32'(m_ovf0));
      check("m_ferr0", 32'(ferr0), 32'(m_ferr));
      check("m_level1", 32'(level1), 32'(q1.size()));
      check("m_valid1", 32'(valid1), 32'(q1.size() != 0));
      if (q1.size() != 0) check("m_data1", 32'(data1), 32'(q1[0]));
      check("m_ovf1", 32'(ovf1), 32'(m_ovf1));
      check("m_ferr1", 32'(ferr1), 32'(m_ferr));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle(input int n);
    chk_en = 1'b1;
    tick(n);
    chk_en = 1'b0;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (q0.size() < DEPTH) q0.push_back(b);
    else m_ovf0 = 1'b1;
    if (q1.size() >= DEPTH) begin
      void'(q1.pop_front());
      m_ovf1 = 1'b1;
    end
    q1.push_back(b);
  endtask

  task automatic model_clear_err();
    m_ovf0 = 1'b0;
    m_ovf1 = 1'b0;
    m_ferr = 1'b0;
  endtask

  // Drive nbits of an 11-bit frame; data changes while ps2_clk is high.
  task automatic send(input logic [7:0] d, input bit bad_par, input int nbits,
                      input bit glitch, input bit pop_sync);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (glitch) begin
        tick(HALF / 2 - 1);
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(HALF / 2 - 1);
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b0;
      for (int c = 0; c < HALF; c++) begin
        tick(1);
        rd_en = pop_sync && (i == 10) && (c == 6);
      end
      ps2_clk = 1'b1;
    end
    tick(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic send_ok(input logic [7:0] d);
    send(d, 1'b0, 11, 1'b0, 1'b0);
    model_push(d);
    settle(4);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    if (q0.size() != 0) void'(q0.pop_front());
    if (q1.size() != 0) void'(q1.pop_front());
    settle(2);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    model_clear_err();
    settle(2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 1'b0;
    clr = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    model_clear_err();
    tick(3);
    check("rst_level", 32'(level0), 32'd0);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_ovf", 32'(ovf1), 32'd0);
    check("rst_ferr", 32'(ferr0), 32'd0);
    clr = 1'b0;
    tick(2);
    settle(4);

    // Basic reception, FWFT ordering
    send_ok(8'h1C); send_ok(8'hF0); send_ok(8'h1C);
    check("t1_level", 32'(level0), 32'd3);
    check("t1_b0", 32'(data0), 32'h1C); pop();
    check("t1_b1", 32'(data0), 32'hF0); pop();
    check("t1_b2", 32'(data0), 32'h1C); pop();
    check("t1_empty", 32'(valid0), 32'd0);
    pop();
    check("t1_no_underflow", 32'(level0), 32'd0);

    // Overflow: drop-newest vs overwrite-oldest
    for (int b = 1; b <= 9; b++) send_ok(8'(b));
    check("t2_level0", 32'(level0), 32'd8);
    check("t2_level1", 32'(level1), 32'd8);
    check("t2_ovf0", 32'(ovf0), 32'd1);
    check("t2_ovf1", 32'(ovf1), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("t2_drop_seq", 32'(data0), 32'(i + 1));
      check("t2_ovw_seq", 32'(data1), 32'(i + 2));
      pop();
    end
    pulse_err_clr();
    check("t2_ovf_clr", 32'(ovf0), 32'd0);

    // Parity error then a good frame
    send(8'h1B, 1'b1, 11, 1'b0, 1'b0);
    m_ferr = 1'b1;
    settle(4);
    check("t3_ferr", 32'(ferr0), 32'd1);
    check("t3_level", 32'(level0), 32'd0);
    pulse_err_clr();
    check("t3_ferr_clr", 32'(ferr0), 32'd0);
    send_ok(8'h1B);
    check("t3_data", 32'(data0), 32'h1B);
    check("t3_valid", 32'(valid0), 32'd1);
    pop();

    // Short glitches on ps2_clk while idle and between bits
    repeat (3) begin
      ps2_clk = 1'b0; tick(2); ps2_clk = 1'b1; tick(20);
    end
    send(8'h5A, 1'b0, 11, 1'b1, 1'b0);
    model_push(8'h5A);
    settle(4);
    check("t4_level", 32'(level0), 32'd1);
    check("t4_data", 32'(data0), 32'h5A);
    check("t4_ferr", 32'(ferr0), 32'd0);
    pop();

    // Mid-frame timeout, then recovery
    send(8'hA5, 1'b0, 4, 1'b0, 1'b0);
    tick(TIMEOUT + 10);
    m_ferr = 1'b1;
    settle(4);
    check("t5_ferr", 32'(ferr0), 32'd1);
    check("t5_level", 32'(level0), 32'd0);
    send_ok(8'h33);
    check("t5_data", 32'(data0), 32'h33);
    pop();
    pulse_err_clr();

    // Pop coincident with the push into a full FIFO
    for (int i = 0; i < 8; i++) send_ok(8'(8'h40 + i));
    check("t6_full", 32'(level0), 32'd8);
    send(8'h48, 1'b0, 11, 1'b0, 1'b1);
    void'(q0.pop_front()); void'(q1.pop_front());
    model_push(8'h48);
    settle(4);
    check("t6_level", 32'(level0), 32'd8);
    check("t6_ovf0", 32'(ovf0), 32'd0);
    check("t6_ovf1", 32'(ovf1), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("t6_seq", 32'(data0), 32'(8'h41 + i));
      pop();
    end

    // Asynchronous reset mid-frame with a non-empty FIFO
    send_ok(8'h77);
    send(8'h12, 1'b0, 5, 1'b0, 1'b0);
    @(posedge clk);
    #3 clr = 1'b1;
    #1;
    check("t6_arst_level", 32'(level0), 32'd0);
    check("t6_arst_valid", 32'(valid0), 32'd0);
    check("t6_arst_ferr", 32'(ferr0), 32'd0);
    check("t6_arst_ovf", 32'(ovf0), 32'd0);
    q0.delete(); q1.delete();
    model_clear_err();
    tick(2);
    clr = 1'b0;
    settle(4);
    send_ok(8'h21);
    check("t6_after_rst", 32'(data0), 32'h21);
    pop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
